// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sample, precharge, N_BITS binary-search
// cycles against an external DAC, then a one-cycle result strobe. SAR_CTRL_OOR_EN adds an input range flag.
module sar_ctrl #(
  parameter int N_BITS   = 8,
  parameter int SMPL_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  real               i_Vin,
  input  real               i_Vdac,
  input  real               i_Vref_L,
  output logic              o_Sprg,
  output logic              o_Ssmpl,
  output logic [N_BITS-1:0] o_trial,
  output logic [N_BITS-1:0] o_code,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_oor
);

  localparam int K_W   = (N_BITS > 2) ? $clog2(N_BITS) : 1;
  localparam int CNT_W = (SMPL_CYC > 1) ? $clog2(SMPL_CYC) : 1;
  localparam logic [K_W-1:0]    K_MSB     = K_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0]  SMPL_LAST = CNT_W'(SMPL_CYC - 1);
  localparam logic [N_BITS-1:0] TRIAL_MSB = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_PRG,
    S_CONV,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [K_W-1:0]     r_k;
  logic [N_BITS-1:0]  r_trial;
  logic [N_BITS-1:0]  r_code;
  real                r_vin_h;
  logic [N_BITS-1:0]  w_trial_nxt;
  logic               w_keep;
  logic               w_smpl_last;
  logic               w_abort;

  assign w_smpl_last = (r_state == S_SAMPLE) && (r_cnt == SMPL_LAST);
  assign w_abort     = i_abort && ((r_state == S_SAMPLE) || (r_state == S_PRG) ||
                                   (r_state == S_CONV));
  assign w_keep      = (r_vin_h >= i_Vdac);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_Sprg      = 1'b0;
    o_Ssmpl     = 1'b0;
    o_valid     = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        o_Ssmpl = 1'b1;
        if (i_abort)          w_state_nxt = S_IDLE;
        else if (w_smpl_last) w_state_nxt = S_PRG;
      end
      S_PRG: begin
        o_Sprg = 1'b1;
        if (i_abort) w_state_nxt = S_IDLE;
        else         w_state_nxt = S_CONV;
      end
      S_CONV: begin
        if (i_abort)          w_state_nxt = S_IDLE;
        else if (r_k == '0)   w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Resolve the current bit and arm the next lower one in the same step.
  always_comb begin
    w_trial_nxt = r_trial;
    if (!w_keep) w_trial_nxt[r_k] = 1'b0;
    if (r_k != '0) w_trial_nxt[r_k - 1'b1] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_k     <= '0;
      r_trial <= '0;
      r_code  <= '0;
      r_vin_h <= 0.0;
    end else if (w_abort) begin
      r_cnt   <= '0;
      r_trial <= '0;
    end else begin
      case (r_state)
        S_SAMPLE: begin
          if (w_smpl_last) begin
            r_cnt   <= '0;
            r_vin_h <= i_Vin;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRG: begin
          r_trial <= TRIAL_MSB;
          r_k     <= K_MSB;
        end
        S_CONV: begin
          r_trial <= w_trial_nxt;
          if (r_k == '0) r_code <= w_trial_nxt;
          else           r_k    <= r_k - 1'b1;
        end
        default: begin
          r_cnt   <= '0;
          r_trial <= '0;
        end
      endcase
    end
  end

  assign o_trial = r_trial;
  assign o_code  = r_code;

`ifdef SAR_CTRL_OOR_EN
  logic r_oor;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oor <= 1'b0;
    end else if (w_abort) begin
      r_oor <= 1'b0;
    end else if (w_smpl_last) begin
      r_oor <= (i_Vin < 0.0) || (i_Vin > i_Vref_L);
    end
  end

  assign o_oor = r_oor;
`else
  real w_unused_vref;

  always_comb w_unused_vref = i_Vref_L;
  assign o_oor = 1'b0;
`endif

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed and randomized bench for sar_ctrl with an ideal DAC in the loop and a
// search-based reference model of the expected conversion result.
module tb_sar_ctrl;
  localparam int N_BITS   = 8;
  localparam int SMPL_CYC = 2;
  localparam int LAT      = SMPL_CYC + N_BITS + 2;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  real        vin, vdac, vref;
  logic       sprg, ssmpl, valid, busy, oor;
  logic [7:0] trial, code;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  always_comb vdac = real'(trial) * vref / 256.0;

  sar_ctrl #(.N_BITS(N_BITS), .SMPL_CYC(SMPL_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_Vin(vin), .i_Vdac(vdac), .i_Vref_L(vref),
    .o_Sprg(sprg), .o_Ssmpl(ssmpl), .o_trial(trial), .o_code(code),
    .o_valid(valid), .o_busy(busy), .o_oor(oor)
  );

  // Largest code whose ideal DAC level does not exceed the input; 0 if none does.
  function automatic int ref_code(input real v, input real r);
    int c = 0;
    for (int k = 0; k < 256; k++)
      if (real'(k) * r / 256.0 <= v) c = k;
    return c;
  endfunction

  function automatic int ref_oor(input real v, input real r);
`ifdef SAR_CTRL_OOR_EN
    return ((v < 0.0) || (v > r)) ? 1 : 0;
`else
    return (v != r) ? 0 : 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input real v, input bit abort_in_done, input string tag);
    int lat;
    int exp;
    exp   = ref_code(v, vref);
    vin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    chk({tag, "_ssmpl"}, {31'd0, ssmpl}, 32'd1);
    while (!valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_code"}, code, exp);
    chk({tag, "_oor"}, {31'd0, oor}, ref_oor(v, vref));
    abort = abort_in_done;
    tick();
    abort = 1'b0;
    chk({tag, "_idle"}, {29'd0, busy, valid, |trial}, 32'd0);
    chk({tag, "_hold"}, code, exp);
  endtask

  initial begin
    int   seen;
    int   lat;
    logic [7:0] prev;
    real  rv;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; vin = 0.0; vref = 1.0;
    tick();
    tick();
    chk("reset_outs", {17'd0, sprg, ssmpl, trial, code, valid, busy, oor}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    start = 1'b1; abort = 1'b1;
    tick();
    chk("start_abort_idle", {31'd0, busy}, 32'd0);
    start = 1'b0; abort = 1'b0;
    tick();

    convert(0.5, 1'b0, "mid");
    chk("mid_const", code, 32'h80);
    convert(0.0, 1'b0, "zero");
    chk("zero_const", code, 32'h00);
    convert(0.999, 1'b1, "full_abort_done");
    chk("full_const", code, 32'hFF);

    // Abort on the third CONV cycle.
    prev = code;
    vin = 0.3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("prg_switch", {30'd0, sprg, ssmpl}, 32'd2);
    chk("prg_trial", trial, 32'd0);
    tick();
    chk("conv1_trial", trial, 32'h80);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_trial", trial, 32'd0);
    chk("abort_code", code, prev);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) seen++;
      tick();
    end
    chk("abort_no_valid", seen, 0);

    // Asynchronous reset in the middle of CONV.
    vin = 0.6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {17'd0, sprg, ssmpl, trial, code, valid, busy, oor}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    convert(0.25, 1'b0, "after_rst");
    chk("after_rst_const", code, 32'h40);

    // Start held high across a whole conversion and beyond.
    vin = 0.7; start = 1'b1;
    tick();
    lat = 1;
    while (!valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("hold_lat", lat, LAT);
    chk("hold_code", code, ref_code(0.7, vref));
    tick();
    chk("hold_gap_idle", {30'd0, busy, valid}, 32'd0);
    tick();
    chk("hold_restart", {30'd0, busy, ssmpl}, 32'd3);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) seen++;
      tick();
    end
    chk("hold_one_valid", seen, 1);

    // Randomized inputs and references, some out of range.
    for (int i = 0; i < 8; i++) begin
      vref = 0.5 + real'($urandom_range(0, 1000)) / 1000.0;
      rv   = vref * (real'($urandom_range(0, 1200)) / 1000.0 - 0.1);
      convert(rv, 1'b0, $sformatf("rnd%0d", i));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
    end

    `ifdef SAR_CTRL_OOR_EN
    vref = 1.0;
    convert(1.2, 1'b0, "oor_high");
    `endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
